// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters with registered
// one-cycle lookup, resolve-stage training, mispredict redirect and statistics.
module branch_predictor #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_valid,
    input  logic [PC_W-1:0]  f_pc,
    input  logic [31:0]      f_instr,
    output logic             pred_valid,
    output logic             pred_is_branch,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             u_valid,
    input  logic [PC_W-1:0]  u_pc,
    input  logic             u_taken,
    input  logic             u_mispredict,
    input  logic [PC_W-1:0]  u_target,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    localparam int         ENTRIES   = 1 << IDX_W;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [1:0]        bht [ENTRIES];
    logic [IDX_W-1:0]  f_idx;
    logic [IDX_W-1:0]  u_idx;
    logic signed [12:0] imm13;
    logic [PC_W-1:0]   f_offset;
    logic              f_is_branch;
    logic              f_taken;
    logic [PC_W-1:0]   f_target;
    logic              squash;
    logic              unused_instr_bits;

    assign f_idx             = f_pc[IDX_W+1:2];
    assign u_idx             = u_pc[IDX_W+1:2];
    assign squash            = u_valid && u_mispredict;
    assign unused_instr_bits = ^f_instr[24:12];

    // Lookup reads the counter before this edge's update, giving old-value
    // semantics when fetch and resolve hit the same entry.
    always_comb begin
        imm13       = {f_instr[31], f_instr[7], f_instr[30:25], f_instr[11:8], 1'b0};
        f_offset    = PC_W'(imm13);
        f_is_branch = (f_instr[6:0] == OP_BRANCH);
        f_taken     = f_is_branch && bht[f_idx][1];
        f_target    = f_taken ? (f_pc + f_offset) : (f_pc + PC_W'(4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (u_valid) begin
            if (u_taken && bht[u_idx] != 2'b11) begin
                bht[u_idx] <= bht[u_idx] + 2'b01;
            end else if (!u_taken && bht[u_idx] != 2'b00) begin
                bht[u_idx] <= bht[u_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid     <= 1'b0;
            pred_is_branch <= 1'b0;
            pred_taken     <= 1'b0;
            pred_target    <= '0;
        end else begin
            pred_valid     <= f_valid && !squash;
            pred_is_branch <= f_is_branch;
            pred_taken     <= f_taken;
            pred_target    <= f_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= squash;
            if (squash) begin
                redirect_pc <= u_taken ? u_target : (u_pc + PC_W'(4));
            end
        end
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (u_valid) begin
            if (br_count != '1) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (u_mispredict && mis_count != '1) begin
                mis_count <= mis_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared every cycle against a table-based reference model.
module tb_branch_predictor;

    localparam int PC_W    = 10;
    localparam int IDX_W   = 6;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int PC_MOD  = 1 << PC_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             f_valid = 1'b0;
    logic [PC_W-1:0]  f_pc = '0;
    logic [31:0]      f_instr = '0;
    logic             pred_valid;
    logic             pred_is_branch;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic             u_valid = 1'b0;
    logic [PC_W-1:0]  u_pc = '0;
    logic             u_taken = 1'b0;
    logic             u_mispredict = 1'b0;
    logic [PC_W-1:0]  u_target = '0;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mis_count;

    branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
        .pred_valid(pred_valid), .pred_is_branch(pred_is_branch),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .u_valid(u_valid), .u_pc(u_pc), .u_taken(u_taken),
        .u_mispredict(u_mispredict), .u_target(u_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .br_count(br_count), .mis_count(mis_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: plain integer counters per table entry.
    int m_bht [1 << IDX_W];
    int m_br;
    int m_mis;

    // Expected outputs for the current cycle, and those for the next edge.
    int exp_pv = 0, exp_br = 0, exp_tk = 0, exp_tg = 0;
    int exp_rv = 0, exp_rpc = 0, exp_bc = 0, exp_mc = 0;
    int nxt_pv, nxt_br, nxt_tk, nxt_tg, nxt_rv, nxt_rpc = 0, nxt_bc, nxt_mc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int wrapPc(input int v);
        return ((v % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    function automatic int branchOffset(input logic [31:0] ins);
        int off;
        off = ins[31] ? -4096 : 0;
        off += int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        return off;
    endfunction

    task automatic modelReset();
        foreach (m_bht[i]) m_bht[i] = 1;
        m_br = 0;
        m_mis = 0;
        exp_pv = 0; exp_br = 0; exp_tk = 0; exp_tg = 0;
        exp_rv = 0; exp_rpc = 0; exp_bc = 0; exp_mc = 0;
        nxt_rpc = 0;
    endtask

    // Drives one cycle of inputs (called just after a rising edge), predicts the
    // outputs for the next edge, advances the model, and returns after that edge.
    task automatic applyStimulus(input logic fv, input logic [PC_W-1:0] fpc, input logic [31:0] fi,
                                 input logic uv, input logic [PC_W-1:0] upc, input logic ut,
                                 input logic um, input logic [PC_W-1:0] utg);
        int fidx, uidx;
        f_valid = fv; f_pc = fpc; f_instr = fi;
        u_valid = uv; u_pc = upc; u_taken = ut; u_mispredict = um; u_target = utg;

        fidx   = (int'(fpc) / 4) % (1 << IDX_W);
        nxt_pv = (fv && !(uv && um)) ? 1 : 0;
        nxt_br = (fi[6:0] == 7'h63) ? 1 : 0;
        nxt_tk = (nxt_br == 1 && m_bht[fidx] >= 2) ? 1 : 0;
        nxt_tg = wrapPc(int'(fpc) + (nxt_tk == 1 ? branchOffset(fi) : 4));
        nxt_rv = (uv && um) ? 1 : 0;
        if (nxt_rv == 1) nxt_rpc = ut ? int'(utg) : wrapPc(int'(upc) + 4);

        if (uv) begin
            uidx = (int'(upc) / 4) % (1 << IDX_W);
            m_bht[uidx] = ut ? ((m_bht[uidx] < 3) ? m_bht[uidx] + 1 : 3)
                             : ((m_bht[uidx] > 0) ? m_bht[uidx] - 1 : 0);
            if (m_br < CNT_MAX) m_br++;
            if (um && m_mis < CNT_MAX) m_mis++;
        end
        nxt_bc = m_br;
        nxt_mc = m_mis;

        @(posedge clk);
        #1;
        exp_pv = nxt_pv; exp_br = nxt_br; exp_tk = nxt_tk; exp_tg = nxt_tg;
        exp_rv = nxt_rv; exp_rpc = nxt_rpc; exp_bc = nxt_bc; exp_mc = nxt_mc;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic holdReset();
        rst_n = 1'b0;
        f_valid = 1'b0; u_valid = 1'b0; u_mispredict = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        checkOutput("pred_valid", 32'(pred_valid), 32'(exp_pv));
        if (exp_pv != 0) begin
            checkOutput("pred_is_branch", 32'(pred_is_branch), 32'(exp_br));
            checkOutput("pred_taken", 32'(pred_taken), 32'(exp_tk));
            checkOutput("pred_target", 32'(pred_target), 32'(exp_tg));
        end
        checkOutput("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
        if (exp_rv != 0) checkOutput("redirect_pc", 32'(redirect_pc), 32'(exp_rpc));
        checkOutput("br_count", 32'(br_count), 32'(exp_bc));
        checkOutput("mis_count", 32'(mis_count), 32'(exp_mc));
    end

    localparam logic [31:0] BEQ_P8  = 32'h0000_0463;
    localparam logic [31:0] BEQ_M16 = 32'hFE00_08E3;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    initial begin
        logic [PC_W-1:0] rpc, rupc;
        logic [31:0] rins;

        modelReset();
        holdReset();
        checkOutput("reset_pred_valid", 32'(pred_valid), 32'd0);
        checkOutput("reset_redirect", 32'(redirect_valid), 32'd0);
        checkOutput("reset_counts", 32'({br_count, mis_count}), 32'd0);

        applyStimulus(1'b1, 10'h010, BEQ_P8, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("beq_cold_valid", 32'(pred_valid), 32'd1);
        checkOutput("beq_cold_taken", 32'(pred_taken), 32'd0);
        checkOutput("beq_cold_target", 32'(pred_target), 32'h014);

        applyStimulus(1'b0, '0, NOP, 1'b1, 10'h010, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, '0, NOP, 1'b1, 10'h010, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, '0, NOP, 1'b1, 10'h004, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, '0, NOP, 1'b1, 10'h004, 1'b1, 1'b0, '0);
        checkOutput("br_count_four", 32'(br_count), 32'd4);

        applyStimulus(1'b1, 10'h010, BEQ_P8, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("beq_trained_taken", 32'(pred_taken), 32'd1);
        checkOutput("beq_trained_target", 32'(pred_target), 32'h018);

        applyStimulus(1'b1, 10'h004, BEQ_M16, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("backward_wrap_target", 32'(pred_target), 32'h3F4);

        applyStimulus(1'b1, 10'h040, BEQ_P8, 1'b1, 10'h040, 1'b1, 1'b0, '0);
        checkOutput("same_cycle_old_taken", 32'(pred_taken), 32'd0);
        applyStimulus(1'b1, 10'h040, BEQ_P8, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("same_cycle_new_taken", 32'(pred_taken), 32'd1);

        applyStimulus(1'b1, 10'h020, NOP, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("nop_is_branch", 32'(pred_is_branch), 32'd0);
        checkOutput("nop_target", 32'(pred_target), 32'h024);
        applyStimulus(1'b1, 10'h3FC, NOP, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("nop_wrap_target", 32'(pred_target), 32'h000);

        applyStimulus(1'b1, 10'h020, NOP, 1'b1, 10'h3FC, 1'b0, 1'b1, '0);
        checkOutput("mis_redirect_valid", 32'(redirect_valid), 32'd1);
        checkOutput("mis_redirect_pc", 32'(redirect_pc), 32'h000);
        checkOutput("mis_squash", 32'(pred_valid), 32'd0);
        checkOutput("mis_count_one", 32'(mis_count), 32'd1);
        idle();
        checkOutput("redirect_one_shot", 32'(redirect_valid), 32'd0);

        applyStimulus(1'b1, 10'h020, NOP, 1'b0, 10'h100, 1'b1, 1'b1, 10'h155);
        checkOutput("ignored_mispredict", 32'(redirect_valid), 32'd0);
        checkOutput("ignored_mis_count", 32'(mis_count), 32'd1);

        applyStimulus(1'b0, '0, NOP, 1'b1, 10'h100, 1'b1, 1'b1, 10'h123);
        checkOutput("taken_redirect_pc", 32'(redirect_pc), 32'h123);
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_redirect_clear", 32'(redirect_valid), 32'd0);
        checkOutput("async_count_clear", 32'({br_count, mis_count}), 32'd0);
        holdReset();
        applyStimulus(1'b1, 10'h010, BEQ_P8, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("bht_reset_taken", 32'(pred_taken), 32'd0);
        applyStimulus(1'b0, '0, NOP, 1'b1, 10'h010, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 10'h010, BEQ_P8, 1'b0, '0, 1'b0, 1'b0, '0);
        checkOutput("bht_reset_weak", 32'(pred_taken), 32'd1);
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_pred_discard", 32'(pred_valid), 32'd0);
        holdReset();

        for (int i = 0; i < 400; i++) begin
            rpc  = 10'($urandom);
            rpc[7:2] = 6'($urandom_range(0, 7));
            rupc = 10'($urandom);
            rupc[7:2] = 6'($urandom_range(0, 7));
            rins = $urandom;
            if ($urandom_range(0, 1) == 1) rins[6:0] = 7'h63;
            applyStimulus(($urandom_range(0, 3) != 0), rpc, rins,
                          ($urandom_range(0, 1) == 1), rupc, ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 3) == 0), 10'($urandom));
            if (i == 200) begin
                #($urandom_range(1, 3));
                rst_n = 1'b0;
                modelReset();
                holdReset();
            end
        end

        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
